// File: rtl/tdm_replay_buffer.sv
// tdm_replay_buffer: records NUM_CH spike lines into one bank of a ping-pong
// pair during a gamma cycle. During the following gamma it replays the other
// bank onto one serial output, channel by channel, decimated by STRIDE.
// Optional build macro REPLAY_OR_COMPRESS_EN: each replayed sample is the OR
// of its whole STRIDE-wide window instead of its first entry, so no spike is
// lost to decimation.
module tdm_replay_buffer #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int STRIDE = 4,
    localparam int KPC    = DEPTH / STRIDE,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W  = (KPC > 1) ? $clog2(KPC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grst,
    input  logic [NUM_CH-1:0] data_in,
    output logic              data_out,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [IDX_W-1:0]  out_idx,
    output logic              bank_sel,
    output logic              wr_ovf,
    output logic              rd_trunc
);

    localparam int SLOTS  = NUM_CH * KPC;
    localparam int PTR_W  = $clog2(DEPTH + 1);
    localparam int SLOT_W = $clog2(SLOTS + 1);
    localparam int AW     = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t             state_q, state_d;
    logic               grst_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   len_q, len_d;
    logic [SLOT_W-1:0]  rd_slot_q, rd_slot_d;
    logic               bank_sel_q, bank_sel_d;
    logic               wr_ovf_q, wr_ovf_d;
    logic               rd_trunc_q, rd_trunc_d;
    logic               data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;

    logic [DEPTH-1:0]   mem_q [2][NUM_CH];
    logic [DEPTH-1:0]   mem_d [2][NUM_CH];

    logic               gb;
    logic               wr_en;
    logic               wr_bank;
    logic [AW-1:0]      wr_addr;
    logic               issue;
    logic [CH_W-1:0]    slot_ch;
    logic [IDX_W-1:0]   slot_k;
    logic [PTR_W-1:0]   base;
    logic [DEPTH-1:0]   row;
    logic               sample;

    // A held-high grst yields a single boundary: only its rising edge counts.
    assign gb = grst & ~grst_q;

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_idx   = out_idx_q;
    assign bank_sel  = bank_sel_q;
    assign wr_ovf    = wr_ovf_q;
    assign rd_trunc  = rd_trunc_q;

    // Decode the current replay slot and fetch its (possibly compressed) sample.
    always_comb begin
        slot_ch = CH_W'(rd_slot_q / SLOT_W'(KPC));
        slot_k  = IDX_W'(rd_slot_q % SLOT_W'(KPC));
        base    = PTR_W'(slot_k) * PTR_W'(STRIDE);
        row     = mem_q[~bank_sel_q][slot_ch];
`ifdef REPLAY_OR_COMPRESS_EN
        sample  = 1'b0;
        for (int j = 0; j < STRIDE; j++) begin
            if ((base + PTR_W'(j)) < len_q) begin
                sample = sample | row[AW'(base + PTR_W'(j))];
            end
        end
`else
        sample  = (base < len_q) ? row[AW'(base)] : 1'b0;
`endif
    end

    // Next-state: FSM, write pointer/length bookkeeping, replay slot issue.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        len_d       = len_q;
        rd_slot_d   = rd_slot_q;
        bank_sel_d  = bank_sel_q;
        wr_ovf_d    = wr_ovf_q;
        rd_trunc_d  = rd_trunc_q;
        wr_en       = 1'b0;
        wr_bank     = bank_sel_q;
        wr_addr     = AW'(wr_ptr_q);

        case (state_q)
            IDLE: begin
                if (gb) begin
                    state_d  = FILL;
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_ptr_d = PTR_W'(1);
                end
            end
            FILL, RUN: begin
                if (gb) begin
                    // wr_ptr never exceeds DEPTH, so it is already the capped length.
                    len_d      = wr_ptr_q;
                    bank_sel_d = ~bank_sel_q;
                    wr_bank    = ~bank_sel_q;
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wr_ptr_d   = PTR_W'(1);
                    rd_slot_d  = '0;
                    // The slot issued this cycle still counts; truncation means
                    // slots remain beyond it.
                    if (state_q == RUN && rd_slot_q < SLOT_W'(SLOTS - 1)) begin
                        rd_trunc_d = 1'b1;
                    end
                    if (state_q == FILL) begin
                        state_d = RUN;
                    end
                end else if (wr_ptr_q < PTR_W'(DEPTH)) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end else begin
                    wr_ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        issue       = (state_q == RUN) && (rd_slot_q < SLOT_W'(SLOTS));
        out_valid_d = issue;
        data_out_d  = issue & sample;
        out_ch_d    = issue ? slot_ch : '0;
        out_idx_d   = issue ? slot_k : '0;
        if (issue && !gb) begin
            rd_slot_d = rd_slot_q + SLOT_W'(1);
        end
    end

    // Bank write port: one entry per channel per cycle into the write bank.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mem_d[wr_bank][ch][wr_addr] = data_in[ch];
            end
        end
    end

    // Bank storage carries no reset; stale contents are masked by len.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grst_q      <= 1'b0;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            rd_slot_q   <= '0;
            bank_sel_q  <= 1'b0;
            wr_ovf_q    <= 1'b0;
            rd_trunc_q  <= 1'b0;
            data_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            grst_q      <= grst;
            wr_ptr_q    <= wr_ptr_d;
            len_q       <= len_d;
            rd_slot_q   <= rd_slot_d;
            bank_sel_q  <= bank_sel_d;
            wr_ovf_q    <= wr_ovf_d;
            rd_trunc_q  <= rd_trunc_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_idx_q   <= out_idx_d;
        end
    end

endmodule

// File: tb/tb_tdm_replay_buffer.sv
// Bench for tdm_replay_buffer with NUM_CH=2, DEPTH=16, STRIDE=2 (16 slots).
module tb_tdm_replay_buffer;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int STRIDE = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              grst;
    logic [NUM_CH-1:0] data_in;
    logic              data_out;
    logic              out_valid;
    logic [0:0]        out_ch;
    logic [2:0]        out_idx;
    logic              bank_sel;
    logic              wr_ovf;
    logic              rd_trunc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_replay_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .STRIDE(STRIDE)) dut (
        .clk(clk), .rst(rst), .grst(grst), .data_in(data_in),
        .data_out(data_out), .out_valid(out_valid), .out_ch(out_ch),
        .out_idx(out_idx), .bank_sel(bank_sel), .wr_ovf(wr_ovf),
        .rd_trunc(rd_trunc)
    );

    typedef struct {
        int          glen;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic g, input logic [NUM_CH-1:0] d);
        grst    = g;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        rst = 1'b0;
    endtask

    function automatic int all_outs();
        return int'({out_valid, data_out, out_ch, out_idx, bank_sel, wr_ovf, rd_trunc});
    endfunction

    initial begin
        int bad;
        rst = 1'b1; grst = 1'b0; data_in = '0;

`ifdef REPLAY_OR_COMPRESS_EN
        vecs[0] = '{16, 32'h0000_8001, 32'h0000_FFFF, 8'h81, 8'hFF, 1'b0};
        vecs[3] = '{16, 32'h0000_AAAA, 32'h0000_5555, 8'hFF, 8'hFF, 1'b0};
        vecs[4] = '{4,  32'h0000_000F, 32'h0000_0002, 8'h03, 8'h01, 1'b0};
`else
        vecs[0] = '{16, 32'h0000_8001, 32'h0000_FFFF, 8'h01, 8'hFF, 1'b0};
        vecs[3] = '{16, 32'h0000_AAAA, 32'h0000_5555, 8'h00, 8'hFF, 1'b0};
        vecs[4] = '{4,  32'h0000_000F, 32'h0000_0002, 8'h03, 8'h00, 1'b0};
`endif
        vecs[1] = '{10, 32'h0000_03FF, 32'h0000_0000, 8'h1F, 8'h00, 1'b0};
        vecs[2] = '{20, 32'h000F_0010, 32'h000F_FFFF, 8'h04, 8'hFF, 1'b1};

        // Reset with toggling grst and random data: everything held at zero.
        for (int i = 0; i < 3; i++) begin
            step(1'(i % 2), NUM_CH'($urandom));
            chk($sformatf("reset_outs_%0d", i), all_outs(), 0);
        end
        rst = 1'b0;
        step(1'b0, NUM_CH'($urandom));
        step(1'b1, NUM_CH'($urandom));
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, NUM_CH'($urandom));
            if (out_valid) bad++;
        end
        chk("no_valid_after_first_gb", bad, 0);
        chk("bank_sel_after_first_gb", int'(bank_sel), 0);
        step(1'b1, NUM_CH'($urandom));
        chk("valid_on_gb_plus1", int'(out_valid), 0);
        step(1'b0, NUM_CH'($urandom));
        chk("valid_on_gb_plus2", int'(out_valid), 1);

        // Table: record one gamma, then check the 16 replay slots that follow.
        foreach (vecs[v]) begin
            do_reset();
            step(1'b0, '0);
            for (int i = 0; i < vecs[v].glen; i++) begin
                step(1'(i == 0), {vecs[v].p1[i], vecs[v].p0[i]});
            end
            chk($sformatf("v%0d_fill_valid", v), int'(out_valid), 0);
            step(1'b1, '0);
            chk($sformatf("v%0d_bank_sel", v), int'(bank_sel), 1);
            chk($sformatf("v%0d_wr_ovf", v), int'(wr_ovf), int'(vecs[v].ovf));
            chk($sformatf("v%0d_gb_valid", v), int'(out_valid), 0);
            for (int s = 0; s < 16; s++) begin
                logic [7:0] e;
                step(1'b0, '0);
                e = (s / 8 == 0) ? vecs[v].e0 : vecs[v].e1;
                chk($sformatf("v%0d_s%0d_valid", v, s), int'(out_valid), 1);
                chk($sformatf("v%0d_s%0d_ch", v, s), int'(out_ch), s / 8);
                chk($sformatf("v%0d_s%0d_idx", v, s), int'(out_idx), s % 8);
                chk($sformatf("v%0d_s%0d_data", v, s), int'(data_out), int'(e[s % 8]));
            end
            step(1'b0, '0);
            chk($sformatf("v%0d_done_valid", v), int'(out_valid), 0);
            chk($sformatf("v%0d_done_data", v), int'(data_out), 0);
            chk($sformatf("v%0d_trunc", v), int'(rd_trunc), 0);
        end

        // Full replay gamma fits exactly; a 12-cycle gamma then truncates.
        do_reset();
        step(1'b0, '0);
        for (int i = 0; i < 16; i++) step(1'(i == 0), 2'b01);
        for (int i = 0; i < 16; i++) step(1'(i == 0), 2'b11);
        step(1'b1, 2'b10);
        chk("full_gamma_no_trunc", int'(rd_trunc), 0);
        chk("full_gamma_last_slot", int'({out_valid, out_ch, out_idx}), 'b1_1_111);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 2'b10);
            if (i == 0) chk("new_replay_slot0", int'({out_valid, out_ch, out_idx}), 'b1_0_000);
        end
        step(1'b1, 2'b00);
        chk("short_gamma_trunc", int'(rd_trunc), 1);
        chk("aborted_slot11", int'({out_valid, out_ch, out_idx}), 'b1_1_011);
        step(1'b0, 2'b00);
        chk("restart_slot0", int'({out_valid, out_ch, out_idx}), 'b1_0_000);
        step(1'b0, 2'b00);
        chk("restart_slot1", int'({out_valid, out_ch, out_idx}), 'b1_0_001);

        // grst held high 40 cycles is a single boundary, both in IDLE and RUN.
        do_reset();
        step(1'b0, '0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 2'b01);
            if (out_valid || bank_sel) bad++;
        end
        chk("hold_idle_one_gb", bad, 0);
        chk("hold_idle_ovf", int'(wr_ovf), 1);
        step(1'b0, 2'b01);
        step(1'b1, 2'b01);
        chk("hold_run_bank_sel", int'(bank_sel), 1);
        step(1'b1, 2'b01);
        chk("hold_run_first_valid", int'(out_valid), 1);
        bad = 0;
        for (int i = 0; i < 38; i++) begin
            step(1'b1, 2'b01);
            if (!bank_sel) bad++;
        end
        chk("hold_run_one_gb", bad, 0);

        // Reset in the middle of a replay.
        do_reset();
        step(1'b0, '0);
        for (int i = 0; i < 20; i++) step(1'(i == 0), 2'b11);
        step(1'b1, '0);
        for (int i = 0; i < 6; i++) step(1'b0, '0);
        chk("mid_slot5", int'({out_valid, out_ch, out_idx}), 'b1_0_101);
        chk("ovf_persists", int'(wr_ovf), 1);
        rst = 1'b1;
        step(1'b0, '0);
        rst = 1'b0;
        chk("mid_reset_outs", all_outs(), 0);
        step(1'b1, '0);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 2'b01);
            if (out_valid) bad++;
        end
        chk("mid_reset_fill_quiet", bad, 0);
        step(1'b1, '0);
        chk("mid_reset_gb2_valid", int'(out_valid), 0);
        chk("mid_reset_gb2_bank", int'(bank_sel), 1);
        step(1'b0, '0);
        chk("mid_reset_resume", int'({out_valid, out_ch, out_idx}), 'b1_0_000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_replay_buffer.md
Name: tdm_replay_buffer

Overview:
- Parametrised successor to the per-input replay buffer and 2:1 muxed wrapper, for time-multiplexed spike input to the macro-column.
- Records NUM_CH spike lines into a ping-pong bank pair for one gamma cycle.
- During the next gamma cycle, replays the recorded bank onto one serial output, channel by channel, decimated by STRIDE.
- Fully synchronous to clk; grst is a level input sampled on clk and rising-edge detected, not used as a clock.

Parameters:
- NUM_CH, 4: number of spike input channels.
- DEPTH, 16: maximum gamma length in clk cycles, i.e. entries per channel per bank. Power of two, >= 4.
- STRIDE, 4: decimation factor. Power of two; DEPTH % STRIDE == 0; NUM_CH <= STRIDE, so a full replay fits in one gamma.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- grst  in  1  gamma boundary level; the rising edge, sampled on clk, marks the start of a gamma cycle.
- data_in  in  NUM_CH  spike bit per channel, one sample per clk.
- data_out  out  1  replayed spike sample, registered.
- out_valid  out  1  data_out carries a replay slot.
- out_ch  out  $clog2(NUM_CH) (min 1)  channel of the current slot.
- out_idx  out  $clog2(DEPTH/STRIDE) (min 1)  decimated index k of the current slot.
- bank_sel  out  1  current write bank.
- wr_ovf  out  1  sticky: a gamma exceeded DEPTH cycles.
- rd_trunc  out  1  sticky: a gamma ended before its replay completed.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, wr_ptr=0, rd_slot=0, len=0, bank_sel=0.
  - All outputs 0, both sticky flags cleared, grst edge-detect register cleared.
  - Bank contents are don't-care.
  - Reset mid-operation behaves identically; outputs are 0 from the following cycle.
- Boundary: gb = grst & ~grst_q. grst held high for many cycles produces one boundary.
- States:
  - IDLE: nothing written, no replay. gb -> FILL.
  - FILL: record only. gb -> RUN.
  - RUN: record and replay; stays in RUN on gb. Only rst leaves RUN.
- Write path (FILL, RUN):
  - Each cycle, bank[bank_sel][ch][wr_ptr] <= data_in[ch] for every ch.
  - wr_ptr saturates at DEPTH. Writes at wr_ptr == DEPTH are dropped and set wr_ovf.
- On a boundary cycle (gb=1, state FILL or RUN):
  - len <= wr_ptr, capped at DEPTH.
  - bank_sel toggles.
  - wr_ptr <= 1, and that cycle's data_in is written to address 0 of the new write bank.
  - rd_slot <= 0.
  - If in RUN with replay incomplete, set rd_trunc.
  - On gb in IDLE, the write to address 0 of bank 0 likewise occurs, and wr_ptr <= 1.
- Replay (RUN only):
  - Read bank = ~bank_sel.
  - Slot s = rd_slot: ch = s / (DEPTH/STRIDE), k = s % (DEPTH/STRIDE).
  - Sample = bank[~bank_sel][ch][k*STRIDE] if k*STRIDE < len, else 0.
  - Registered output, latency 1: the slot computed in cycle t appears on data_out/out_ch/out_idx with out_valid=1 in cycle t+1.
  - First valid output is the cycle after the cycle following the boundary.
  - rd_slot runs 0 .. NUM_CH*DEPTH/STRIDE-1, then replay is complete: out_valid=0, data_out=0 until the next boundary.
  - A boundary aborts the current replay; the next slot issued is slot 0 of the newly swapped bank.
- Widths: all counters are sized for DEPTH inclusive. No arithmetic wrap; saturate or compare as stated.

Optional Feature:
- Macro REPLAY_OR_COMPRESS_EN.
- Defined: sample = OR of bank[rd][ch][k*STRIDE .. k*STRIDE+STRIDE-1], counting only addresses < len. A spike anywhere in the window survives compression.
- Undefined: plain decimation as specified above.
- Timing and handshake are identical in both builds.

Test Plan (NUM_CH=2, DEPTH=16, STRIDE=2 unless noted):
- Reset: rst=1 for 3 cycles, random data_in, grst toggling -> all outputs 0, flags 0; no out_valid until after the second gb.
- Basic replay: gamma of 16 cycles; ch0 gets 1 at cycles 0 and 15 only, ch1 all ones.
  - Next gamma, 16 valid slots: ch0 k0..7 = 1,0,0,0,0,0,0,0, then ch1 = eight 1s, with out_ch/out_idx matching.
  - Same stimulus with REPLAY_OR_COMPRESS_EN defined: ch0 = 1,0,0,0,0,0,0,1.
- Short gamma: 10-cycle gamma, ch0 all ones -> ch0 slots k0..4 = 1, k5..7 = 0 (len masking); wr_ovf stays 0.
- Long gamma: 20-cycle gamma, then normal gamma -> wr_ovf=1, replay len=16, entries 16..19 absent; flag persists until rst.
- Truncation and edge detection:
  - NUM_CH=4, STRIDE=4: a 12-cycle gamma follows a full one -> rd_trunc=1 and replay restarts at slot 0.
  - grst held high for 40 cycles -> exactly one boundary.
- Reset mid-replay: rst at slot 5 -> out_valid=0 next cycle, state IDLE, flags 0; two new gb are required before replay resumes.
